// File: rtl/shift_sched_pkg.sv
// shift_pkg: op encodings, width and amount conversion for shift_sched.
// Op 10 is legal only when SHIFT_SCHED_ROR_EN is defined.
package shift_pkg;

    localparam int W = 16;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRA = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef struct packed {
        logic         id;
        logic [1:0]   op;
        logic [5:0]   sel;
        logic [W-1:0] data;
    } s1_t;

    typedef struct packed {
        logic         id;
        logic         err;
        logic [W-1:0] data;
    } resp_t;

    // Greedy base-3 split: sel = {d2, d1, d0}, amt = d0 + 3*d1 + 9*d2.
    function automatic logic [5:0] amt_to_tern(input logic [3:0] amt);
        logic [3:0] r;
        logic [1:0] d2;
        logic [1:0] d1;
        logic [1:0] d0;
        if (amt >= 4'd9) begin
            d2 = 2'd1;
            r  = amt - 4'd9;
        end else begin
            d2 = 2'd0;
            r  = amt;
        end
        if (r >= 4'd6) begin
            d1 = 2'd2;
            d0 = 2'(r - 4'd6);
        end else if (r >= 4'd3) begin
            d1 = 2'd1;
            d0 = 2'(r - 4'd3);
        end else begin
            d1 = 2'd0;
            d0 = 2'(r);
        end
        return {d2, d1, d0};
    endfunction

    function automatic logic op_legal(input logic [1:0] op);
`ifdef SHIFT_SCHED_ROR_EN
        return op != OP_RSV;
`else
        return (op == OP_SLL) || (op == OP_SRA);
`endif
    endfunction

endpackage

// File: rtl/shift_sched_if.sv
// shift_sched_if: two request ports and one response channel,
// all valid/ready handshakes.
interface shift_sched_if;
    import shift_pkg::*;

    logic         req0_valid;
    logic         req0_ready;
    logic [1:0]   req0_op;
    logic [3:0]   req0_amt;
    logic [W-1:0] req0_data;

    logic         req1_valid;
    logic         req1_ready;
    logic [1:0]   req1_op;
    logic [3:0]   req1_amt;
    logic [W-1:0] req1_data;

    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_id;
    logic         resp_err;

    modport master (
        output req0_valid, req0_op, req0_amt, req0_data,
        output req1_valid, req1_op, req1_amt, req1_data,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_data, resp_id, resp_err
    );

    modport slave (
        input  req0_valid, req0_op, req0_amt, req0_data,
        input  req1_valid, req1_op, req1_amt, req1_data,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_data, resp_id, resp_err
    );

endinterface

// File: rtl/shift_sched_core.sv
// shift_core: combinational three-stage base-3 shifter (1, 3, 9).
// Rotate path exists only when SHIFT_SCHED_ROR_EN is defined.
module shift_core
    import shift_pkg::*;
(
    input  logic [1:0]   op,
    input  logic [5:0]   sel,
    input  logic [W-1:0] data,
    output logic [W-1:0] result
);

    logic [4:0]   n0;
    logic [4:0]   n1;
    logic [4:0]   n2;
    logic [W-1:0] st0;
    logic [W-1:0] st1;

    function automatic logic [W-1:0] stage(
        input logic [1:0]   o,
        input logic [W-1:0] d,
        input logic [4:0]   n
    );
        logic [W-1:0] r;
        r = d;
        unique case (o)
            OP_SLL:  r = d << n;
            OP_SRA:  r = $unsigned($signed(d) >>> n);
`ifdef SHIFT_SCHED_ROR_EN
            // Rotating by 16 is identity, so only n mod 16 matters.
            OP_ROR:  r = W'({d, d} >> n[3:0]);
`endif
            default: r = d;
        endcase
        return r;
    endfunction

    assign n0 = {3'b000, sel[1:0]};
    assign n1 = 5'(sel[3:2]) * 5'd3;
    assign n2 = 5'(sel[5:4]) * 5'd9;

    assign st0    = stage(op, data, n0);
    assign st1    = stage(op, st0, n1);
    assign result = stage(op, st1, n2);

endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin two-port scheduler over one shifter,
// S1 operand register then S2 response register.
module shift_sched
    import shift_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    shift_sched_if.slave bus,
    output logic         busy
);

    logic         last;
    logic         grant0;
    logic         grant1;
    logic         acc0;
    logic         acc1;
    logic         can_accept;
    logic         s1_valid;
    logic         s1_adv;
    logic         resp_valid;
    logic         err;
    logic [W-1:0] core_out;
    s1_t          s1_q;
    s1_t          s1_d;
    resp_t        resp_q;

    // Tie goes to the port that did not win last.
    assign grant0 = bus.req0_valid & (~bus.req1_valid | last);
    assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last);

    assign s1_adv     = s1_valid & (~resp_valid | bus.resp_ready);
    assign can_accept = rst_n & (~s1_valid | s1_adv);

    assign bus.req0_ready = grant0 & can_accept;
    assign bus.req1_ready = grant1 & can_accept;

    assign acc0 = bus.req0_ready;
    assign acc1 = bus.req1_ready;

    always_comb begin
        s1_d = s1_q;
        unique case (1'b1)
            acc0: s1_d = '{
                id:   1'b0,
                op:   bus.req0_op,
                sel:  amt_to_tern(bus.req0_amt),
                data: bus.req0_data
            };
            acc1: s1_d = '{
                id:   1'b1,
                op:   bus.req1_op,
                sel:  amt_to_tern(bus.req1_amt),
                data: bus.req1_data
            };
            default: s1_d = s1_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 1'b1;
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (acc0 | acc1)
                last <= acc1;
            if (can_accept)
                s1_valid <= acc0 | acc1;
            s1_q <= s1_d;
        end
    end

    shift_core u_core (
        .op     (s1_q.op),
        .sel    (s1_q.sel),
        .data   (s1_q.data),
        .result (core_out)
    );

    assign err = ~op_legal(s1_q.op);

    // A drain and a refill in the same cycle keep resp_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_q     <= '0;
        end else if (s1_adv) begin
            resp_valid <= 1'b1;
            resp_q     <= '{
                id:   s1_q.id,
                err:  err,
                data: err ? s1_q.data : core_out
            };
        end else if (bus.resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_q.data;
    assign bus.resp_id    = resp_q.id;
    assign bus.resp_err   = resp_q.err;

    assign busy = s1_valid | resp_valid;

endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: randomized scoreboard bench for shift_sched.
// Expected results come from an arithmetic shift model.
`timescale 1ns/1ps
module tb_shift_sched;
    import shift_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    logic rr;

    logic        cv[2];
    logic [1:0]  cop[2];
    logic [3:0]  camt[2];
    logic [15:0] cdata[2];

    shift_sched_if bus();

    shift_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    assign bus.req0_valid = cv[0];
    assign bus.req0_op    = cop[0];
    assign bus.req0_amt   = camt[0];
    assign bus.req0_data  = cdata[0];
    assign bus.req1_valid = cv[1];
    assign bus.req1_op    = cop[1];
    assign bus.req1_amt   = camt[1];
    assign bus.req1_data  = cdata[1];
    assign bus.resp_ready = rr;

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_pop = -100;
    int   n_acc = 0;
    bit   m_last = 1'b1;
    bit   acc_f[2];
    bit   auto_on[2];
    int   auto_pct = 100;
    bit   rr_rand = 1'b0;

    task automatic chk(input bit ok, input string nm,
                       input int act, input int req);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                     nm, act, req, cyc);
        end
    endtask

    // Reference: shifts as arithmetic on plain integers.
    function automatic exp_t model(input int id, input logic [1:0] op,
                                   input logic [3:0] amt,
                                   input logic [15:0] d, input int acc);
        exp_t        e;
        int unsigned x;
        int          sx;
        int          a;
        x      = d;
        sx     = int'($signed(d));
        a      = amt;
        e.id   = id;
        e.acc  = acc;
        e.err  = 1'b0;
        e.data = d;
        case (op)
            2'd0: e.data = 16'((x * (32'd1 << a)) & 32'hFFFF);
            2'd1: e.data = 16'(sx >>> a);
            2'd2: begin
`ifdef SHIFT_SCHED_ROR_EN
                e.data = 16'(((x >> a) | (x << (16 - a))) & 32'hFFFF);
`else
                e.err = 1'b1;
`endif
            end
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: response scoreboard, timing and arbitration checks.
    always @(negedge clk) begin
        int   inflight;
        int   vis;
        bit   g0;
        bit   g1;
        bit   room;
        exp_t e;
        if (!rst_n) begin
            chk(bus.resp_valid === 1'b0, "rst resp_valid", bus.resp_valid, 0);
            chk(bus.resp_data === 16'h0, "rst resp_data", bus.resp_data, 0);
            chk(bus.resp_id === 1'b0, "rst resp_id", bus.resp_id, 0);
            chk(bus.resp_err === 1'b0, "rst resp_err", bus.resp_err, 0);
            chk(busy === 1'b0, "rst busy", busy, 0);
            chk(bus.req0_ready === 1'b0, "rst req0_ready", bus.req0_ready, 0);
            chk(bus.req1_ready === 1'b0, "rst req1_ready", bus.req1_ready, 0);
            q.delete();
            m_last   = 1'b1;
            acc_f[0] = 1'b0;
            acc_f[1] = 1'b0;
            last_pop = -100;
        end else begin
            inflight = q.size();
            chk(busy === (inflight > 0), "busy", busy, inflight > 0);
            if (inflight == 0) begin
                chk(bus.resp_valid === 1'b0, "spurious resp", bus.resp_valid, 0);
            end else begin
                e   = q[0];
                vis = e.acc + 2;
                if (last_pop + 1 > vis)
                    vis = last_pop + 1;
                if (cyc >= vis) begin
                    chk(bus.resp_valid === 1'b1, "resp_valid", bus.resp_valid, 1);
                    if (bus.resp_valid === 1'b1) begin
                        chk(bus.resp_data === e.data, "resp_data",
                            bus.resp_data, e.data);
                        chk(bus.resp_id === e.id[0], "resp_id", bus.resp_id, e.id);
                        chk(bus.resp_err === e.err, "resp_err", bus.resp_err, e.err);
                        if (rr) begin
                            void'(q.pop_front());
                            last_pop = cyc;
                        end
                    end
                end else begin
                    chk(bus.resp_valid === 1'b0, "early resp", bus.resp_valid, 0);
                end
            end
            room = (inflight < 2) || rr;
            g0   = cv[0] && (!cv[1] || m_last);
            g1   = cv[1] && (!cv[0] || !m_last);
            chk(bus.req0_ready === (g0 && room), "req0_ready",
                bus.req0_ready, g0 && room);
            chk(bus.req1_ready === (g1 && room), "req1_ready",
                bus.req1_ready, g1 && room);
            if (cv[0] && bus.req0_ready === 1'b1) begin
                q.push_back(model(0, cop[0], camt[0], cdata[0], cyc));
                m_last   = 1'b0;
                acc_f[0] = 1'b1;
                n_acc++;
            end else if (cv[1] && bus.req1_ready === 1'b1) begin
                q.push_back(model(1, cop[1], camt[1], cdata[1], cyc));
                m_last   = 1'b1;
                acc_f[1] = 1'b1;
                n_acc++;
            end
        end
    end

    // Driver: retires accepted commands and refills in auto mode.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (acc_f[i]) begin
                acc_f[i] = 1'b0;
                cv[i]    = 1'b0;
            end
            if (!cv[i] && auto_on[i] && $urandom_range(0, 99) < auto_pct) begin
                cop[i]   = 2'($urandom_range(0, 3));
                camt[i]  = 4'($urandom_range(0, 15));
                cdata[i] = 16'($urandom);
                cv[i]    = 1'b1;
            end
        end
        if (rr_rand)
            rr = ($urandom_range(0, 3) != 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input int p, input logic [1:0] op,
                        input logic [3:0] amt, input logic [15:0] d);
        for (int t = 0; t < 100 && cv[p]; t++)
            tick(1);
        chk(!cv[p], "send wait", cv[p], 0);
        cop[p]   = op;
        camt[p]  = amt;
        cdata[p] = d;
        cv[p]    = 1'b1;
    endtask

    task automatic drain();
        auto_on[0] = 1'b0;
        auto_on[1] = 1'b0;
        for (int t = 0; t < 300 && (q.size() != 0 || cv[0] || cv[1]); t++)
            tick(1);
        tick(2);
        chk(q.size() == 0 && !cv[0] && !cv[1], "drain", q.size(), 0);
    endtask

    initial begin
        int n0;
        rst_n    = 1'b0;
        rr       = 1'b0;
        cv[0]    = 1'b0;
        cv[1]    = 1'b0;
        cop[0]   = 2'd0;
        cop[1]   = 2'd0;
        camt[0]  = 4'd0;
        camt[1]  = 4'd0;
        cdata[0] = 16'h0;
        cdata[1] = 16'h0;
        auto_on[0] = 1'b0;
        auto_on[1] = 1'b0;
        tick(3);
        rst_n = 1'b1;
        rr    = 1'b1;

        send(0, OP_SRA, 4'd15, 16'h8000);
        send(0, OP_SLL, 4'd15, 16'h0001);
        send(0, OP_ROR, 4'd4, 16'h1234);
        send(1, OP_ROR, 4'd4, 16'h1234);
        send(1, OP_RSV, 4'd7, 16'hBEEF);
        send(0, OP_SLL, 4'd0, 16'hA5C3);
        drain();

        n0 = n_acc;
        auto_pct   = 100;
        auto_on[0] = 1'b1;
        auto_on[1] = 1'b1;
        for (int t = 0; t < 50 && n_acc < n0 + 6; t++)
            tick(1);
        chk(n_acc >= n0 + 6, "tie stream", n_acc - n0, 6);
        drain();

        rr = 1'b0;
        n0 = n_acc;
        auto_on[0] = 1'b1;
        auto_on[1] = 1'b1;
        tick(5);
        chk(n_acc - n0 == 2, "stall accepts", n_acc - n0, 2);
        rr = 1'b1;
        tick(3);
        drain();

        rr_rand = 1'b1;
        for (int op = 0; op < 4; op++)
            for (int a = 0; a < 16; a++)
                send(int'($urandom_range(0, 1)), 2'(op), 4'(a), 16'hA5C3);
        drain();

        auto_pct   = 60;
        auto_on[0] = 1'b1;
        auto_on[1] = 1'b1;
        tick(300);
        drain();
        rr_rand = 1'b0;
        rr      = 1'b1;

        auto_pct   = 100;
        rr         = 1'b0;
        auto_on[0] = 1'b1;
        auto_on[1] = 1'b1;
        tick(4);
        chk(busy === 1'b1 && bus.resp_valid === 1'b1, "full before rst",
            busy, 1);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        rr    = 1'b1;
        tick(20);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
